pe_fp32_int8_ws: RTL and testbench

Weight-stationary successor to the FP32×int8 pipelined processing element for the systolic array. The active int8 weight is held inside the PE and double-buffered through a shadow register on a per-column shift chain, so the next weight tile loads while the current one computes. The input operand is forwarded to the right-hand neighbour, and the multiplier input pipeline depth is a parameter. An in-flight counter reports when the PE is drained.

---
 rtl/pe_fp32_int8_ws.sv | 258 +++++++++++++++++++++++++
 tb/tb_pe_fp32_int8_ws.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_fp32_int8_ws.sv
// Weight-stationary FP32 x int8 processing element for the systolic array.
// Denormal operands are flushed to zero; arithmetic rounds to nearest-even.

module FP32_int8_mult (
  input  logic [31:0] a,
  input  logic [7:0]  w,
  output logic [31:0] p
);
  logic        sgn, rup;
  logic [7:0]  mag;
  logic [3:0]  lz;
  logic [31:0] prod, norm;
  logic [9:0]  exp_r;
  logic [32:0] rnd;
  logic        unused_hidden;

  // Leading one of the 24x8 product sits at bit 23..31; normalise it to bit 31
  always_comb begin
    sgn  = a[31] ^ w[7];
    mag  = w[7] ? (~w + 8'd1) : w;
    prod = {8'd0, 1'b1, a[22:0]} * {24'd0, mag};
    lz   = 4'd8;
    for (int i = 0; i <= 8; i++)
      if (prod[23+i]) lz = 4'(8 - i);
    norm  = prod << lz;
    exp_r = {2'b00, a[30:23]} + 10'd8 - {6'd0, lz};
    rup   = norm[7] & ((|norm[6:0]) | norm[8]);
    rnd   = {exp_r, norm[30:8]} + {32'd0, rup};
    if (a[30:23] == 8'hFF)
      p = ((|a[22:0]) || (mag == 8'd0)) ? 32'h7FC00000 : {sgn, 8'hFF, 23'd0};
    else if (mag == 8'd0)
      p = 32'd0;
    else if (a[30:23] == 8'd0)
      p = {sgn, 31'd0};
    else if (rnd[32:23] >= 10'd255)
      p = {sgn, 8'hFF, 23'd0};
    else
      p = {sgn, rnd[30:0]};
  end

  assign unused_hidden = norm[31];
endmodule

module Fp32_Adder_Latency3 (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  output logic [31:0] sum
);
  typedef struct packed {
    logic v, spec, sgn, sub, zs;
    logic [31:0] sval;
    logic [7:0]  exp;
    logic [26:0] ma, mb;
  } s1_t;
  typedef struct packed {
    logic v, spec, sgn, zs;
    logic [31:0] sval;
    logic [7:0]  exp;
    logic [27:0] mag;
  } s2_t;

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  logic        v3_d, v3_q, rup, nan_a, nan_b, inf_a, inf_b;
  logic [31:0] r3_d, r3_q, big, sml;
  logic [26:0] ms, mask, n;
  logic [7:0]  diff;
  logic [4:0]  lz;
  logic [9:0]  e;
  logic [32:0] rnd;
  logic        unused_hidden;

  // Order operands by magnitude and align the smaller one, folding lost bits into a sticky bit
  always_comb begin
    big   = (b[30:0] > a[30:0]) ? b : a;
    sml   = (b[30:0] > a[30:0]) ? a : b;
    ms    = (sml[30:23] == 8'd0) ? 27'd0 : {1'b1, sml[22:0], 3'b000};
    diff  = big[30:23] - sml[30:23];
    mask  = (27'd1 << diff) - 27'd1;
    nan_a = (a[30:23] == 8'hFF) && (|a[22:0]);
    nan_b = (b[30:23] == 8'hFF) && (|b[22:0]);
    inf_a = (a[30:23] == 8'hFF) && !(|a[22:0]);
    inf_b = (b[30:23] == 8'hFF) && !(|b[22:0]);
    s1_d.v    = in_valid;
    s1_d.spec = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
    s1_d.sval = (nan_a || nan_b || (inf_a && inf_b && (a[31] != b[31]))) ? 32'h7FC00000 :
                (inf_a ? a : b);
    s1_d.sgn  = big[31];
    s1_d.sub  = big[31] ^ sml[31];
    s1_d.zs   = a[31] & b[31];
    s1_d.exp  = big[30:23];
    s1_d.ma   = (big[30:23] == 8'd0) ? 27'd0 : {1'b1, big[22:0], 3'b000};
    s1_d.mb   = (ms >> diff) | {26'd0, |(ms & mask)};

    s2_d.v    = s1_q.v;
    s2_d.spec = s1_q.spec;
    s2_d.sgn  = s1_q.sgn;
    s2_d.zs   = s1_q.zs;
    s2_d.sval = s1_q.sval;
    s2_d.exp  = s1_q.exp;
    s2_d.mag  = s1_q.sub ? ({1'b0, s1_q.ma} - {1'b0, s1_q.mb})
                         : ({1'b0, s1_q.ma} + {1'b0, s1_q.mb});
  end

  // Normalise, round, and resolve zero / underflow / overflow; exact zero takes sign a&b
  always_comb begin
    lz = 5'd0;
    for (int i = 0; i < 27; i++)
      if (s2_q.mag[i]) lz = 5'(26 - i);
    if (s2_q.mag[27]) begin
      n = {s2_q.mag[27:2], |s2_q.mag[1:0]};
      e = {2'b00, s2_q.exp} + 10'd1;
    end else begin
      n = s2_q.mag[26:0] << lz;
      e = {2'b00, s2_q.exp} - {5'd0, lz};
    end
    rup  = n[2] & (n[3] | n[1] | n[0]);
    rnd  = {e, n[25:3]} + {32'd0, rup};
    v3_d = s2_q.v;
    if (s2_q.spec)                  r3_d = s2_q.sval;
    else if (s2_q.mag == 28'd0)     r3_d = {s2_q.zs, 31'd0};
    else if (e[9] || e == 10'd0)    r3_d = {s2_q.sgn, 31'd0};
    else if (rnd[32:23] >= 10'd255) r3_d = {s2_q.sgn, 8'hFF, 23'd0};
    else                            r3_d = {s2_q.sgn, rnd[30:0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
      v3_q <= 1'b0;
      r3_q <= 32'd0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      v3_q <= v3_d;
      r3_q <= r3_d;
    end
  end

  assign out_valid     = v3_q;
  assign sum           = r3_q;
  assign unused_hidden = n[26];
endmodule

module pe_fp32_int8_ws #(
  parameter int MULT_PIPE = 1,
  parameter bit FWD_EN    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in,
  input  logic        input_valid,
  input  logic [31:0] acc,
  output logic [31:0] out,
  output logic        output_valid,
  output logic [31:0] in_fwd,
  output logic        in_fwd_valid,
  input  logic [7:0]  w_shift_in,
  input  logic        w_shift_en,
  output logic [7:0]  w_shift_out,
  input  logic        w_commit,
  output logic        idle
);
  localparam int CW = $clog2(MULT_PIPE + 5);
  typedef struct packed { logic v; logic [7:0] w; logic [31:0] d; } op_t;

  logic [7:0]    w_sh_d, w_sh_q, w_act_d, w_act_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic [31:0]   prod_d, prod_q;
  logic          prod_v_d, prod_v_q;
  op_t           op_in, mult_op;

  // Each operation captures the active weight on entry so later commits cannot disturb it
  always_comb begin
    w_sh_d   = w_shift_en ? w_shift_in : w_sh_q;
    w_act_d  = w_commit ? w_sh_q : w_act_q;
    op_in    = {input_valid, w_act_q, in};
    prod_v_d = mult_op.v;
    cnt_d    = cnt_q;
    case ({input_valid, output_valid})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  generate
    if (MULT_PIPE == 0) begin : g_nopipe
      always_comb mult_op = op_in;
    end else begin : g_pipe
      op_t [MULT_PIPE-1:0] stage_d, stage_q;
      always_comb begin
        stage_d    = stage_q;
        stage_d[0] = op_in;
        for (int i = 1; i < MULT_PIPE; i++) stage_d[i] = stage_q[i-1];
      end
      always_ff @(posedge clk) begin
        if (reset) stage_q <= '0;
        else       stage_q <= stage_d;
      end
      always_comb mult_op = stage_q[MULT_PIPE-1];
    end

    if (FWD_EN) begin : g_fwd
      logic [31:0] fwd_d, fwd_q;
      logic        fwd_v_d, fwd_v_q;
      always_comb begin
        fwd_d   = in;
        fwd_v_d = input_valid;
      end
      always_ff @(posedge clk) begin
        if (reset) begin
          fwd_q   <= 32'd0;
          fwd_v_q <= 1'b0;
        end else begin
          fwd_q   <= fwd_d;
          fwd_v_q <= fwd_v_d;
        end
      end
      assign in_fwd       = fwd_q;
      assign in_fwd_valid = fwd_v_q;
    end else begin : g_nofwd
      assign in_fwd       = 32'd0;
      assign in_fwd_valid = 1'b0;
    end
  endgenerate

  FP32_int8_mult u_mult (.a(mult_op.d), .w(mult_op.w), .p(prod_d));

  always_ff @(posedge clk) begin
    if (reset) begin
      w_sh_q   <= 8'd0;
      w_act_q  <= 8'd0;
      cnt_q    <= '0;
      prod_q   <= 32'd0;
      prod_v_q <= 1'b0;
    end else begin
      w_sh_q   <= w_sh_d;
      w_act_q  <= w_act_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      prod_v_q <= prod_v_d;
    end
  end

  Fp32_Adder_Latency3 u_add (
    .clk(clk), .reset(reset), .in_valid(prod_v_q), .a(prod_q), .b(acc),
    .out_valid(output_valid), .sum(out)
  );

  assign w_shift_out = w_sh_q;
  assign idle        = (cnt_q == '0);
endmodule

// File: tb/tb_pe_fp32_int8_ws.sv
// Directed scoreboard bench for pe_fp32_int8_ws; extra instances cover MULT_PIPE=0 and 3.

module tb_pe_fp32_int8_ws;
  localparam logic [31:0] ZERO  = 32'h00000000;
  localparam logic [31:0] NEGZ  = 32'h80000000;
  localparam logic [31:0] HALF  = 32'h3F000000;
  localparam logic [31:0] ONE   = 32'h3F800000;
  localparam logic [31:0] TWO   = 32'h40000000;
  localparam logic [31:0] THREE = 32'h40400000;
  localparam logic [31:0] FIVE  = 32'h40A00000;
  localparam logic [31:0] SEVEN = 32'h40E00000;
  localparam logic [31:0] MONE  = 32'hBF800000;
  localparam logic [31:0] GARB  = 32'h42000000;

  typedef struct { logic [31:0] val; int cyc; } exp_t;

  logic        clk, reset, input_valid, w_shift_en, w_commit;
  logic [31:0] in, acc, acc0, acc3;
  logic [7:0]  w_shift_in;
  logic [31:0] out, in_fwd, out0, out3, fwd0, fwd3;
  logic        output_valid, in_fwd_valid, idle, ov0, ov3, fv0, fv3, idle0, idle3;
  logic [7:0]  w_shift_out, wso0, wso3;
  logic        unused_sink;

  int   compared, mismatched, cyc, peak;
  exp_t sbq[$];

  logic [31:0] in_tab  [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                               32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
  logic [31:0] out_tab [8] = '{32'hBFC00000, 32'hC0600000, 32'hC0B00000, 32'hC0F00000,
                               32'hC1180000, 32'hC1380000, 32'hC1580000, 32'hC1780000};

  pe_fp32_int8_ws dut (
    .clk(clk), .reset(reset), .in(in), .input_valid(input_valid), .acc(acc),
    .out(out), .output_valid(output_valid), .in_fwd(in_fwd), .in_fwd_valid(in_fwd_valid),
    .w_shift_in(w_shift_in), .w_shift_en(w_shift_en), .w_shift_out(w_shift_out),
    .w_commit(w_commit), .idle(idle)
  );
  pe_fp32_int8_ws #(.MULT_PIPE(0)) dut0 (
    .clk(clk), .reset(reset), .in(in), .input_valid(input_valid), .acc(acc0),
    .out(out0), .output_valid(ov0), .in_fwd(fwd0), .in_fwd_valid(fv0),
    .w_shift_in(w_shift_in), .w_shift_en(w_shift_en), .w_shift_out(wso0),
    .w_commit(w_commit), .idle(idle0)
  );
  pe_fp32_int8_ws #(.MULT_PIPE(3)) dut3 (
    .clk(clk), .reset(reset), .in(in), .input_valid(input_valid), .acc(acc3),
    .out(out3), .output_valid(ov3), .in_fwd(fwd3), .in_fwd_valid(fv3),
    .w_shift_in(w_shift_in), .w_shift_en(w_shift_en), .w_shift_out(wso3),
    .w_commit(w_commit), .idle(idle3)
  );
  assign unused_sink = ^{fwd0, fv0, wso0, idle0, fwd3, fv3, wso3, idle3};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic [31:0] a,
                               input logic push, input logic [31:0] expv);
    exp_t ent;
    input_valid = v;
    in   = d;
    acc  = a;
    acc0 = a;
    acc3 = a;
    if (push) begin
      ent.val = expv;
      ent.cyc = cyc + 5;
      sbq.push_back(ent);
    end
  endtask

  // Advance one cycle and compare output_valid/out against the scoreboard head
  task automatic nextCycle();
    exp_t ent;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
      ent = sbq.pop_front();
      checkOutput("sb_valid", 32'(output_valid), 32'd1);
      checkOutput("sb_out", out, ent.val);
    end else begin
      checkOutput("sb_no_valid", 32'(output_valid), 32'd0);
    end
  endtask

  task automatic loadWeight(input logic [7:0] w);
    w_shift_in = w;
    w_shift_en = 1'b1;
    nextCycle();
    w_shift_en = 1'b0;
    w_commit   = 1'b1;
    nextCycle();
    w_commit   = 1'b0;
  endtask

  task automatic runSingle(input logic [31:0] d, input logic [31:0] a, input logic [31:0] expv);
    applyStimulus(1'b1, d, a, 1'b1, expv);
    nextCycle();
    applyStimulus(1'b0, GARB, a, 1'b0, ZERO);
    repeat (6) nextCycle();
  endtask

  initial begin
    compared = 0; mismatched = 0; cyc = 0; peak = 0;
    reset = 1'b1; w_shift_en = 1'b0; w_commit = 1'b0; w_shift_in = 8'd0;
    applyStimulus(1'b0, ZERO, ZERO, 1'b0, ZERO);
    @(posedge clk); @(posedge clk); @(negedge clk);
    checkOutput("rst_out", out, ZERO);
    checkOutput("rst_valid", 32'(output_valid), 32'd0);
    checkOutput("rst_in_fwd", in_fwd, ZERO);
    checkOutput("rst_in_fwd_valid", 32'(in_fwd_valid), 32'd0);
    checkOutput("rst_w_shift_out", 32'(w_shift_out), 32'd0);
    checkOutput("rst_idle", 32'(idle), 32'd1);
    reset = 1'b0;

    // Basic MAC 2.0*3+1.0 on all three pipeline depths, acc valid only at the sample cycle
    $display("[TB] basic MAC and MULT_PIPE sweep");
    w_shift_in = 8'd3;
    w_shift_en = 1'b1;
    nextCycle();
    w_shift_en = 1'b0;
    checkOutput("shift_out_3", 32'(w_shift_out), 32'd3);
    w_commit = 1'b1;
    nextCycle();
    w_commit = 1'b0;
    checkOutput("w_act_3", 32'(dut.w_act_q), 32'd3);
    applyStimulus(1'b1, TWO, GARB, 1'b1, SEVEN);
    for (int k = 1; k <= 7; k++) begin
      nextCycle();
      applyStimulus(1'b0, GARB, (k == 2) ? ONE : GARB, 1'b0, ZERO);
      acc0 = (k == 1) ? ONE : GARB;
      acc3 = (k == 4) ? ONE : GARB;
      if (k == 1) checkOutput("idle_busy", 32'(idle), 32'd0);
      if (k == 3) checkOutput("mp0_early", 32'(ov0), 32'd0);
      if (k == 4) begin
        checkOutput("mp0_valid", 32'(ov0), 32'd1);
        checkOutput("mp0_out", out0, SEVEN);
      end
      if (k == 5) checkOutput("idle_at_out", 32'(idle), 32'd0);
      if (k == 6) begin
        checkOutput("idle_after", 32'(idle), 32'd1);
        checkOutput("mp3_early", 32'(ov3), 32'd0);
      end
      if (k == 7) begin
        checkOutput("mp3_valid", 32'(ov3), 32'd1);
        checkOutput("mp3_out", out3, SEVEN);
      end
    end

    // Commit while the first operation is in flight
    $display("[TB] commit mid-flight");
    loadWeight(8'd2);
    applyStimulus(1'b1, ONE, ZERO, 1'b1, TWO);
    w_shift_in = 8'hFF;
    w_shift_en = 1'b1;
    nextCycle();
    applyStimulus(1'b0, GARB, ZERO, 1'b0, ZERO);
    w_shift_en = 1'b0;
    w_commit   = 1'b1;
    checkOutput("shadow_m1", 32'(w_shift_out), 32'h000000FF);
    nextCycle();
    w_commit = 1'b0;
    checkOutput("w_act_m1", 32'(dut.w_act_q), 32'h000000FF);
    applyStimulus(1'b1, ONE, ZERO, 1'b1, MONE);
    nextCycle();
    applyStimulus(1'b0, GARB, ZERO, 1'b0, ZERO);
    repeat (6) nextCycle();

    // Shift and commit together: active takes the old shadow
    $display("[TB] shift with simultaneous commit");
    w_shift_in = 8'd5;
    w_shift_en = 1'b1;
    nextCycle();
    checkOutput("shift_out_5", 32'(w_shift_out), 32'd5);
    w_shift_in = 8'd7;
    w_commit   = 1'b1;
    nextCycle();
    w_shift_en = 1'b0;
    w_commit   = 1'b0;
    checkOutput("sim_w_act", 32'(dut.w_act_q), 32'd5);
    checkOutput("sim_shift_out", 32'(w_shift_out), 32'd7);

    // Eight back-to-back operations with w=-2, acc=0.5
    $display("[TB] streaming");
    loadWeight(8'hFE);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, in_tab[k], HALF, 1'b1, out_tab[k]);
      nextCycle();
      if (int'(dut.cnt_q) > peak) peak = int'(dut.cnt_q);
      checkOutput("fwd_data", in_fwd, in_tab[k]);
      checkOutput("fwd_valid", 32'(in_fwd_valid), 32'd1);
    end
    applyStimulus(1'b0, GARB, HALF, 1'b0, ZERO);
    for (int k = 0; k < 7; k++) begin
      nextCycle();
      if (int'(dut.cnt_q) > peak) peak = int'(dut.cnt_q);
      if (k == 0) checkOutput("fwd_valid_off", 32'(in_fwd_valid), 32'd0);
    end
    checkOutput("cnt_peak", 32'(peak), 32'd5);
    checkOutput("stream_idle", 32'(idle), 32'd1);
    checkOutput("stream_drained", 32'(sbq.size()), 32'd0);

    // Reset while three operations are in flight; inputs during reset are ignored
    $display("[TB] reset mid-operation");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, in_tab[k], HALF, 1'b0, ZERO);
      nextCycle();
    end
    applyStimulus(1'b0, GARB, HALF, 1'b0, ZERO);
    nextCycle();
    reset = 1'b1;
    applyStimulus(1'b1, THREE, HALF, 1'b0, ZERO);
    w_shift_in = 8'h55;
    w_shift_en = 1'b1;
    w_commit   = 1'b1;
    nextCycle();
    nextCycle();
    reset = 1'b0;
    w_shift_en = 1'b0;
    w_commit   = 1'b0;
    applyStimulus(1'b0, GARB, HALF, 1'b0, ZERO);
    checkOutput("post_rst_idle", 32'(idle), 32'd1);
    checkOutput("post_rst_w_act", 32'(dut.w_act_q), 32'd0);
    checkOutput("post_rst_w_sh", 32'(w_shift_out), 32'd0);
    checkOutput("post_rst_fwd_valid", 32'(in_fwd_valid), 32'd0);
    repeat (8) nextCycle();

    // Zero weight passes acc through; -0 acc follows the adder's signed-zero rule
    $display("[TB] zero weight");
    runSingle(THREE, FIVE, FIVE);
    runSingle(THREE, NEGZ, ZERO);
    checkOutput("final_drained", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
